// File: rtl/adsr_envelope_poly.sv
// Multi-voice linear ADSR envelope generator.
// Each voice owns a stage register, a level register and the gate value
// seen on the previous tick. Slopes and sustain are shared by all voices.
// All state advances only on tick_i; outputs come straight from registers.
module adsr_envelope_poly #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_VOICES = 4,
  parameter int STEP_WIDTH = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             tick_i,
  input  logic [NUM_VOICES-1:0]            gate_i,
  input  logic [STEP_WIDTH-1:0]            attack_step_i,
  input  logic [STEP_WIDTH-1:0]            decay_step_i,
  input  logic [DATA_WIDTH-2:0]            sustain_level_i,
  input  logic [STEP_WIDTH-1:0]            release_step_i,
  output logic [NUM_VOICES*DATA_WIDTH-1:0] envelope_o,
  output logic [NUM_VOICES*3-1:0]          stage_o,
  output logic [NUM_VOICES-1:0]            active_o,
  output logic                             valid_o
);

  // Level is kept without the sign bit; the output MSB is always 0.
  localparam int LW = DATA_WIDTH - 1;
  // One bit of headroom above the wider operand so add/sub never wrap.
  localparam int AW = ((STEP_WIDTH > LW) ? STEP_WIDTH : LW) + 1;
  localparam logic [LW-1:0] LVL_MAX = '1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  logic [NUM_VOICES-1:0][2:0]    stage_q, stage_d;
  logic [NUM_VOICES-1:0][LW-1:0] level_q, level_d;
  logic [NUM_VOICES-1:0]         gate_prev_q, gate_prev_d;
  logic                          valid_q;
  logic [NUM_VOICES-1:0]         rise, fall;

  // Saturating increment: min(a + s, LVL_MAX).
  function automatic logic [LW-1:0] sat_add(input logic [LW-1:0] a,
                                            input logic [STEP_WIDTH-1:0] s);
    logic [AW-1:0] sum;
    sum = AW'(a) + AW'(s);
    if (sum >= AW'(LVL_MAX)) return LVL_MAX;
    return sum[LW-1:0];
  endfunction

  // Clamped decrement: max(a - s, floor_lvl), computed without wrapping.
  function automatic logic [LW-1:0] sat_sub(input logic [LW-1:0] a,
                                            input logic [STEP_WIDTH-1:0] s,
                                            input logic [LW-1:0] floor_lvl);
    logic [AW-1:0] diff;
    if (AW'(s) >= AW'(a)) return floor_lvl;
    diff = AW'(a) - AW'(s);
    if (diff <= AW'(floor_lvl)) return floor_lvl;
    return diff[LW-1:0];
  endfunction

  assign rise = gate_i & ~gate_prev_q;
  assign fall = ~gate_i & gate_prev_q;

  // Next-state for every voice: edge ticks only move the stage, other ticks run the slope.
  always_comb begin
    stage_d     = stage_q;
    level_d     = level_q;
    gate_prev_d = gate_prev_q;
    if (tick_i) begin
      gate_prev_d = gate_i;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (rise[v]) begin
          stage_d[v] = ST_ATTACK;
        end else if (fall[v] && (stage_q[v] == ST_ATTACK || stage_q[v] == ST_DECAY ||
                                 stage_q[v] == ST_SUSTAIN)) begin
          stage_d[v] = ST_RELEASE;
        end else begin
          case (stage_q[v])
            ST_ATTACK: begin
              // A zero step means an instant segment straight to the target.
              if (attack_step_i == '0) level_d[v] = LVL_MAX;
              else                     level_d[v] = sat_add(level_q[v], attack_step_i);
              if (attack_step_i == '0 || sat_add(level_q[v], attack_step_i) == LVL_MAX)
                stage_d[v] = ST_DECAY;
            end
            ST_DECAY: begin
              // sat_sub also covers a sustain raised above the current level.
              if (decay_step_i == '0 ||
                  sat_sub(level_q[v], decay_step_i, sustain_level_i) == sustain_level_i) begin
                level_d[v] = sustain_level_i;
                stage_d[v] = ST_SUSTAIN;
              end else begin
                level_d[v] = sat_sub(level_q[v], decay_step_i, sustain_level_i);
              end
            end
            ST_SUSTAIN: begin
              level_d[v] = sustain_level_i;
            end
            ST_RELEASE: begin
              if (release_step_i == '0 ||
                  sat_sub(level_q[v], release_step_i, '0) == '0) begin
                level_d[v] = '0;
                stage_d[v] = ST_IDLE;
              end else begin
                level_d[v] = sat_sub(level_q[v], release_step_i, '0);
              end
            end
            default: begin
              level_d[v] = '0;
              stage_d[v] = ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  // State registers; everything clears asynchronously so outputs read 0 during reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q     <= '0;
      level_q     <= '0;
      gate_prev_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      level_q     <= level_d;
      gate_prev_q <= gate_prev_d;
      valid_q     <= tick_i;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign envelope_o[g*DATA_WIDTH +: DATA_WIDTH] = {1'b0, level_q[g]};
    assign active_o[g] = (stage_q[g] != ST_IDLE);
  end

  assign stage_o = stage_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_adsr_envelope_poly.sv
// Directed bench for adsr_envelope_poly (DATA_WIDTH=16, 4 voices).
module tb_adsr_envelope_poly;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [3:0]  gate;
  logic [15:0] att, dec, rel;
  logic [14:0] sus;
  logic [63:0] env;
  logic [11:0] stg;
  logic [3:0]  act;
  logic        vld;

  int checks = 0;
  int errors = 0;

  adsr_envelope_poly #(.DATA_WIDTH(16), .NUM_VOICES(4), .STEP_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .gate_i(gate),
    .attack_step_i(att), .decay_step_i(dec), .sustain_level_i(sus),
    .release_step_i(rel), .envelope_o(env), .stage_o(stg),
    .active_o(act), .valid_o(vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check level, stage and active of one voice.
  task automatic chkv(input string tag, input int v, input int lvl, input int st);
    chk({tag, " level"}, 32'(env[v*16 +: 16]), 32'(lvl));
    chk({tag, " stage"}, 32'(stg[v*3 +: 3]), 32'(st));
    chk({tag, " active"}, 32'(act[v]), 32'(st != 0));
  endtask

  // One tick pulse; valid must be high for exactly the following cycle.
  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    chk("valid_hi", 32'(vld), 32'd1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("valid_lo", 32'(vld), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; gate = 4'b0000;
    att = 16'd8192; dec = 16'd4096; rel = 16'd4096; sus = 15'd16384;
    #23;
    chk("rst env", 32'(env), 32'd0);
    chk("rst stage", 32'(stg), 32'd0);
    chk("rst valid", 32'(vld), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Scenario 1: full attack/decay into sustain on voice 0
    gate = 4'b0001;
    do_tick(); chkv("s1 edge", 0, 0, 1);
    idle_cycle();
    do_tick(); chkv("s1 a1", 0, 8192, 1);
    do_tick(); chkv("s1 a2", 0, 16384, 1);
    do_tick(); chkv("s1 a3", 0, 24576, 1);
    do_tick(); chkv("s1 a4", 0, 32767, 2);
    do_tick(); chkv("s1 d1", 0, 28671, 2);
    do_tick(); chkv("s1 d2", 0, 24575, 2);
    do_tick(); chkv("s1 d3", 0, 20479, 2);
    do_tick(); chkv("s1 d4", 0, 16384, 3);
    do_tick(); chkv("s1 hold", 0, 16384, 3);

    // Scenario 2: release from 16384 down to idle
    gate = 4'b0000;
    do_tick(); chkv("s2 edge", 0, 16384, 4);
    do_tick(); chkv("s2 r1", 0, 12288, 4);
    do_tick(); chkv("s2 r2", 0, 8192, 4);
    do_tick(); chkv("s2 r3", 0, 4096, 4);
    do_tick(); chkv("s2 r4", 0, 0, 0);

    // Gate fall during attack, then retrigger during release
    gate = 4'b0001;
    do_tick(); chkv("s2 rise", 0, 0, 1);
    do_tick(); do_tick(); chkv("s2 a16k", 0, 16384, 1);
    gate = 4'b0000;
    do_tick(); chkv("s2 fall_att", 0, 16384, 4);
    do_tick(); do_tick(); chkv("s3 r8k", 0, 8192, 4);
    gate = 4'b0001;
    do_tick(); chkv("s3 retrig", 0, 8192, 1);
    do_tick(); chkv("s3 a1", 0, 16384, 1);
    do_tick(); chkv("s3 a2", 0, 24576, 1);
    do_tick(); chkv("s3 a3", 0, 32767, 2);

    // Scenario 4: zero steps are instant segments
    att = 16'd0; dec = 16'd0; rel = 16'd0; sus = 15'd1000;
    do_tick(); chkv("s4 dec0", 0, 1000, 3);
    sus = 15'd2000;
    do_tick(); chkv("s4 sus_live", 0, 2000, 3);
    sus = 15'd1000;
    do_tick(); chkv("s4 sus_back", 0, 1000, 3);
    gate = 4'b0000;
    do_tick(); chkv("s4 fall", 0, 1000, 4);
    do_tick(); chkv("s4 rel0", 0, 0, 0);
    gate = 4'b0001;
    do_tick(); chkv("s4 rise", 0, 0, 1);
    do_tick(); chkv("s4 att0", 0, 32767, 2);
    do_tick(); chkv("s4 dec0b", 0, 1000, 3);

    // Scenario 5: independent voices 0 and 2
    @(negedge clk) rst_n = 1'b0;
    gate = 4'b0000;
    att = 16'd8192; dec = 16'd4096; rel = 16'd4096; sus = 15'd16384;
    @(negedge clk) rst_n = 1'b1;
    gate = 4'b0001;
    do_tick(); chkv("s5 v0 edge", 0, 0, 1);
    gate = 4'b0101;
    do_tick(); chkv("s5 v0 t1", 0, 8192, 1); chkv("s5 v2 edge", 2, 0, 1);
    do_tick(); chkv("s5 v0 t2", 0, 16384, 1); chkv("s5 v2 t1", 2, 8192, 1);
    chkv("s5 v1", 1, 0, 0); chkv("s5 v3", 3, 0, 0);
    do_tick(); do_tick();
    chkv("s5 v0 t4", 0, 32767, 2); chkv("s5 v2 t3", 2, 24576, 1);
    do_tick(); chkv("s5 v0 t5", 0, 28671, 2); chkv("s5 v2 t4", 2, 32767, 2);
    idle_cycle();
    do_tick(); do_tick(); do_tick();
    chkv("s5 v0 sus", 0, 16384, 3); chkv("s5 v2 t7", 2, 20479, 2);
    chkv("s5 v1 end", 1, 0, 0); chkv("s5 v3 end", 3, 0, 0);

    // Scenario 6: asynchronous reset mid-sustain with gate held
    #3 rst_n = 1'b0;
    #1;
    chk("s6 rst env", 32'(env), 32'd0);
    chk("s6 rst stage", 32'(stg), 32'd0);
    chk("s6 rst active", 32'(act), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    do_tick(); chkv("s6 v0 att", 0, 0, 1); chkv("s6 v2 att", 2, 0, 1);
    gate = 4'b0000;
    idle_cycle(); idle_cycle();
    chkv("s6 notick v0", 0, 0, 1);
    gate = 4'b0101;
    idle_cycle();
    gate = 4'b0000;
    idle_cycle();
    chkv("s6 notick v2", 2, 0, 1);
    do_tick(); chkv("s6 fall v0", 0, 0, 4);
    do_tick(); chkv("s6 idle v0", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
